// File: rtl/sin_cos_pkg.sv
// Shared constants, state type and float packing helper for the sin_cos CORDIC unit.
// Angles are Q4.28, CORDIC vectors are Q2.30.
package sin_cos_pkg;

    localparam logic [31:0] PI      = 32'h3243_F6A9;
    localparam logic [31:0] HALF_PI = 32'h1921_FB54;
    localparam logic [31:0] TWO_PI  = 32'h6487_ED51;

    localparam logic signed [31:0] CORDIC_K = 32'sh26DD_3B6A;

    // atan(2^-i) in Q4.28
    localparam logic signed [31:0] ATAN_TAB [0:27] = '{
        32'sd210828714, 32'sd124459457, 32'sd65760959, 32'sd33381290,
        32'sd16755422,  32'sd8385879,   32'sd4193963,  32'sd2097109,
        32'sd1048571,   32'sd524287,    32'sd262144,   32'sd131072,
        32'sd65536,     32'sd32768,     32'sd16384,    32'sd8192,
        32'sd4096,      32'sd2048,      32'sd1024,     32'sd512,
        32'sd256,       32'sd128,       32'sd64,       32'sd32,
        32'sd16,        32'sd8,         32'sd4,        32'sd2
    };

    typedef enum logic [1:0] {IDLE, REDUCE, ROTATE, PACK} state_t;

    localparam logic [31:0] FP_NAN  = 32'h7FC0_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    // Q2.30 -> IEEE single, round-to-nearest-even; neg flips the result sign.
    function automatic logic [31:0] fix_to_float(input logic signed [31:0] v, input logic neg);
        logic [31:0] mag;
        logic [31:0] norm;
        logic        sgn;
        logic        rnd;
        logic        found;
        logic [4:0]  lz;
        logic [7:0]  expo;
        logic [24:0] mant;
        logic [31:0] res;
        mag   = v[31] ? $unsigned(-v) : $unsigned(v);
        sgn   = v[31] ^ neg;
        lz    = 5'd0;
        found = 1'b0;
        for (int b = 31; b >= 0; b--) begin
            if (!found && mag[b]) begin
                lz    = 5'(31 - b);
                found = 1'b1;
            end
        end
        norm = mag << lz;
        rnd  = norm[7] & ((|norm[6:0]) | norm[8]);
        mant = {1'b0, norm[31:8]} + {24'd0, rnd};
        expo = 8'd128 - {3'd0, lz};
        if (mant[24]) begin
            expo = expo + 8'd1;
            mant = mant >> 1;
        end
        if (mag < 32'd64)
            res = FP_ZERO;
        else if (mag >= 32'h3FFF_FFC0)
            res = {sgn, FP_ONE[30:0]};
        else
            res = {sgn, expo, mant[22:0]};
        return res;
    endfunction

endpackage

// File: rtl/sin_cos_cordic.sv
// Iterative rotation-mode CORDIC: one micro-rotation per enabled cycle,
// x starts at the gain constant so no output scaling is needed.
module sin_cos_cordic
    import sin_cos_pkg::*;
#(
    parameter int ITERATIONS = 24
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               load_i,
    input  logic               rot_en_i,
    input  logic signed [31:0] z0_i,
    output logic signed [31:0] x_o,
    output logic signed [31:0] y_o,
    output logic               last_o
);

    logic signed [31:0] x_q, y_q, z_q;
    logic signed [31:0] x_d, y_d, z_d;
    logic signed [31:0] x_sh, y_sh, atan_w;
    logic [4:0]         cnt_q, cnt_d;

    always_comb begin
        x_sh   = x_q >>> cnt_q;
        y_sh   = y_q >>> cnt_q;
        atan_w = ATAN_TAB[cnt_q];
        cnt_d  = cnt_q + 5'd1;
        if (z_q[31]) begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_w;
        end else begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_w;
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            x_q   <= CORDIC_K;
            y_q   <= '0;
            z_q   <= z0_i;
            cnt_q <= '0;
        end else if (rot_en_i) begin
            x_q   <= x_d;
            y_q   <= y_d;
            z_q   <= z_d;
            cnt_q <= cnt_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (cnt_q == 5'(ITERATIONS - 1));

endmodule

// File: rtl/sin_cos.sv
// sin/cos of an IEEE single angle: convert, reduce to a quadrant, CORDIC, pack.
// Define SIN_COS_NEG_INPUT_EN to honour the input sign; otherwise |opx| is used.
module sin_cos
    import sin_cos_pkg::*;
#(
    parameter int ITERATIONS = 24
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        sine_start,
    input  logic [31:0] opx,
    output logic        sine_done,
    output logic [31:0] sine_result,
    output logic [31:0] cosine_result
);

    state_t             state_q, state_d;
    logic [31:0]        angle_q;
    logic               zero_q, nan_q, done_q;
    logic [1:0]         quad_q, quad_c;
    logic [31:0]        sin_q, cos_q, sin_d, cos_d;
    logic [7:0]         exp_w;
    logic [31:0]        mant_ext, conv_c, a_c, r_c;
    logic signed [31:0] cx, cy;
    logic               last_c, accept, sin_flip;

    assign accept = (state_q == IDLE) && sine_start;

    // Magnitude to Q4.28; values >= 8 overflow here but are flagged NaN anyway.
    always_comb begin
        exp_w    = opx[30:23];
        mant_ext = {8'h00, 1'b1, opx[22:0]};
        if (exp_w >= 8'd122)
            conv_c = mant_ext << (exp_w - 8'd122);
        else
            conv_c = mant_ext >> (8'd122 - exp_w);
    end

    // Input is below 4*pi, so one 2*pi subtraction fully reduces it.
    always_comb begin
        a_c = (angle_q >= TWO_PI) ? angle_q - TWO_PI : angle_q;
        if (a_c >= PI + HALF_PI) begin
            quad_c = 2'd3;
            r_c    = a_c - (PI + HALF_PI);
        end else if (a_c >= PI) begin
            quad_c = 2'd2;
            r_c    = a_c - PI;
        end else if (a_c >= HALF_PI) begin
            quad_c = 2'd1;
            r_c    = a_c - HALF_PI;
        end else begin
            quad_c = 2'd0;
            r_c    = a_c;
        end
    end

    sin_cos_cordic #(.ITERATIONS(ITERATIONS)) u_cordic (
        .clk     (clk),
        .n_rst   (n_rst),
        .load_i  (state_q == REDUCE),
        .rot_en_i(state_q == ROTATE),
        .z0_i    ($signed(r_c)),
        .x_o     (cx),
        .y_o     (cy),
        .last_o  (last_c)
    );

`ifdef SIN_COS_NEG_INPUT_EN
    logic neg_q;
    always_ff @(posedge clk) begin
        if (n_rst)
            neg_q <= 1'b0;
        else if (accept)
            neg_q <= opx[31];
    end
    assign sin_flip = neg_q;
`else
    logic unused_sign;
    assign unused_sign = opx[31];
    assign sin_flip    = 1'b0;
`endif

    // Quadrant q rotates (cos r, sin r) by q*pi/2.
    always_comb begin
        sin_d = FP_ZERO;
        cos_d = FP_ZERO;
        case (quad_q)
            2'd0: begin sin_d = fix_to_float(cy, sin_flip);  cos_d = fix_to_float(cx, 1'b0); end
            2'd1: begin sin_d = fix_to_float(cx, sin_flip);  cos_d = fix_to_float(cy, 1'b1); end
            2'd2: begin sin_d = fix_to_float(cy, ~sin_flip); cos_d = fix_to_float(cx, 1'b1); end
            default: begin sin_d = fix_to_float(cx, ~sin_flip); cos_d = fix_to_float(cy, 1'b0); end
        endcase
        if (nan_q) begin
            sin_d = FP_NAN;
            cos_d = FP_NAN;
        end else if (zero_q) begin
            sin_d = FP_ZERO;
            cos_d = FP_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sine_start) state_d = REDUCE;
            REDUCE:  state_d = ROTATE;
            ROTATE:  if (last_c) state_d = PACK;
            PACK:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q <= IDLE;
            angle_q <= '0;
            zero_q  <= 1'b0;
            nan_q   <= 1'b0;
            quad_q  <= '0;
            done_q  <= 1'b0;
            sin_q   <= FP_ZERO;
            cos_q   <= FP_ZERO;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == PACK);
            if (accept) begin
                angle_q <= conv_c;
                zero_q  <= (exp_w == 8'd0);
                nan_q   <= (exp_w >= 8'd130);
            end
            if (state_q == REDUCE)
                quad_q <= quad_c;
            if (state_q == PACK) begin
                sin_q <= sin_d;
                cos_q <= cos_d;
            end
        end
    end

    assign sine_done     = done_q;
    assign sine_result   = sin_q;
    assign cosine_result = cos_q;

endmodule

// File: tb/tb_sin_cos.sv
// Directed and randomized checks of sin_cos against a real-arithmetic reference
// ($sin/$cos of the decoded input angle).
module tb_sin_cos;

    localparam int  ITER = 24;
    localparam real TOL  = 1.0 / 1048576.0;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        sine_start;
    logic [31:0] opx;
    logic        sine_done;
    logic [31:0] sine_result;
    logic [31:0] cosine_result;

    int n_cmp = 0;
    int n_bad = 0;

    sin_cos #(.ITERATIONS(ITER)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .sine_start   (sine_start),
        .opx          (opx),
        .sine_done    (sine_done),
        .sine_result  (sine_result),
        .cosine_result(cosine_result)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    task automatic chk_bits(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_near(input string tag, input logic [31:0] obs, input real exp_r);
        real d;
        bit  ok;
        d  = f2r(obs) - exp_r;
        if (d < 0.0) d = -d;
        ok = (obs[30:23] != 8'hFF) && (d <= TOL);
        n_cmp++;
        assert (ok === 1'b1) else begin
            n_bad++;
            $error("FAIL %s observed=%h (%g) expected=%g", tag, obs, f2r(obs), exp_r);
        end
    endtask

    // Launch one request; returns at the cycle in which sine_done is seen.
    task automatic run_op(input logic [31:0] a, input bit noise,
                          output logic [31:0] s, output logic [31:0] c, output int lat);
        @(negedge clk);
        opx        = a;
        sine_start = 1'b1;
        @(negedge clk);
        sine_start = 1'b0;
        opx        = $urandom();
        lat        = -1;
        for (int n = 1; n <= ITER + 20; n++) begin
            @(posedge clk);
            #1;
            if (sine_done) begin
                lat = n;
                break;
            end
            if (noise && n < ITER - 4) begin
                sine_start = 1'($urandom_range(0, 1));
                opx        = $urandom();
            end else begin
                sine_start = 1'b0;
            end
        end
        sine_start = 1'b0;
        s = sine_result;
        c = cosine_result;
    endtask

    task automatic check_op(input string tag, input logic [31:0] a, input bit noise,
                            output logic [31:0] s, output logic [31:0] c);
        int  lat;
        real v;
        run_op(a, noise, s, c, lat);
        chk_int({tag, " latency"}, lat, ITER + 2);
        if (a[30:23] == 8'd0) begin
            chk_bits({tag, " sin"}, s, 32'h0000_0000);
            chk_bits({tag, " cos"}, c, 32'h3F80_0000);
        end else if (a[30:23] >= 8'd130) begin
            chk_bits({tag, " sin"}, s, 32'h7FC0_0000);
            chk_bits({tag, " cos"}, c, 32'h7FC0_0000);
        end else begin
            v = f2r(a);
`ifndef SIN_COS_NEG_INPUT_EN
            if (v < 0.0) v = -v;
`endif
            chk_near({tag, " sin"}, s, $sin(v));
            chk_near({tag, " cos"}, c, $cos(v));
        end
        $display("op %-10s opx=%h sin=%h cos=%h latency=%0d", tag, a, s, c, lat);
    endtask

    initial begin
        logic [31:0] s, c, hold_s, hold_c;
        logic [31:0] a;
        bit          seen;
        n_rst      = 1'b1;
        sine_start = 1'b0;
        opx        = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_bits("reset sin", sine_result, 32'h0);
        chk_bits("reset cos", cosine_result, 32'h0);
        chk_int("reset done", int'(sine_done), 0);
        @(negedge clk);
        n_rst = 1'b0;

        check_op("pi/4", 32'h3F49_0FD8, 1'b0, s, c);
        hold_s = s;
        hold_c = c;
        @(posedge clk);
        #1;
        chk_int("done width", int'(sine_done), 0);
        repeat (3) @(posedge clk);
        #1;
        chk_bits("hold sin", sine_result, hold_s);
        chk_bits("hold cos", cosine_result, hold_c);

        check_op("pi/2", 32'h3FC9_0FD8, 1'b0, s, c);
        chk_bits("pi/2 sin exact", s, 32'h3F80_0000);
        check_op("3pi/2", 32'h4096_CBE4, 1'b0, s, c);
        chk_bits("3pi/2 sin exact", s, 32'hBF80_0000);
        check_op("7pi/4", 32'h40AF_EDDF, 1'b0, s, c);
        check_op("2pi", 32'h40C9_0FDB, 1'b0, s, c);
        chk_bits("2pi cos exact", c, 32'h3F80_0000);
        check_op("inf", 32'h7F80_0000, 1'b0, s, c);
        check_op("nan", 32'h7FC1_2345, 1'b0, s, c);
        check_op("eight", 32'h4100_0000, 1'b0, s, c);
        check_op("zero", 32'h0000_0000, 1'b0, s, c);
        check_op("negzero", 32'h8000_0000, 1'b0, s, c);
        check_op("denorm", 32'h0000_0001, 1'b0, s, c);
        check_op("neg1", 32'hBF80_0000, 1'b0, s, c);
        check_op("busy_noise", 32'h4020_0000, 1'b1, s, c);

        // Abort mid-computation with a reset pulse.
        @(negedge clk);
        opx        = 32'h3F49_0FD8;
        sine_start = 1'b1;
        @(negedge clk);
        sine_start = 1'b0;
        repeat (9) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        n_rst = 1'b0;
        chk_bits("abort sin", sine_result, 32'h0);
        chk_bits("abort cos", cosine_result, 32'h0);
        seen = 1'b0;
        for (int n = 0; n < ITER + 10; n++) begin
            @(posedge clk);
            #1;
            seen = seen | sine_done;
        end
        chk_int("abort no done", int'(seen), 0);
        $display("op abort     reset mid-run done_seen=%0d", seen);
        check_op("after_rst", 32'h3F00_0000, 1'b0, s, c);

        // Back-to-back random requests, some with ignored busy-time starts.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 19) == 0)
                a = ($urandom_range(0, 1) == 1) ? 32'h7F80_0000 : 32'h0000_0000;
            else
                a = {1'($urandom_range(0, 1)), 8'($urandom_range(112, 129)), 23'($urandom())};
            check_op($sformatf("rnd%0d", t), a, $urandom_range(0, 3) == 0, s, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
